// File: rtl/alu_serial_sequencer.sv
// Bit-serial ALU: accepts one request, computes one result bit per cycle LSB first,
// then presents the registered result with carry/zero/err until the consumer takes it.
module alu_serial_sequencer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             err
);

    localparam int IW = $clog2(WIDTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_NOT = 3'b011;
    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, result_q, result_d;
    logic [2:0]       op_q, op_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             cin_q, cin_d, carry_q, carry_d, zero_q, zero_d;
    logic             err_q, err_d, out_valid_q, out_valid_d;

    logic a_bit, b_eff, res_bit, cout, is_arith, is_illegal;

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        idx_d       = idx_q;
        cin_d       = cin_q;
        acc_d       = acc_q;
        result_d    = result_q;
        carry_d     = carry_q;
        zero_d      = zero_q;
        err_d       = err_q;
        out_valid_d = out_valid_q;

        is_arith   = (op_q == OP_ADD) || (op_q == OP_SUB);
        is_illegal = op_q[2] & op_q[1];
        a_bit      = a_q[idx_q];
        // SUB is A + ~B with the carry chain seeded to 1 at accept time
        b_eff      = (op_q == OP_SUB) ? ~b_q[idx_q] : b_q[idx_q];
        cout       = (a_bit & b_eff) | (cin_q & (a_bit ^ b_eff));

        case (op_q)
            OP_AND:         res_bit = a_bit & b_q[idx_q];
            OP_OR:          res_bit = a_bit | b_q[idx_q];
            OP_XOR:         res_bit = a_bit ^ b_q[idx_q];
            OP_NOT:         res_bit = ~a_bit;
            OP_ADD, OP_SUB: res_bit = a_bit ^ b_eff ^ cin_q;
            default:        res_bit = 1'b0;
        endcase

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = A;
                    b_d     = B;
                    op_d    = op;
                    idx_d   = '0;
                    cin_d   = (op == OP_SUB);
                    acc_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                acc_d[idx_q] = res_bit;
                if (is_arith) cin_d = cout;
                idx_d = idx_q + IW'(1);
                if (idx_q == LAST_IDX) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    result_d    = acc_d;
                    carry_d     = is_arith ? cout : 1'b0;
                    zero_d      = (acc_d == '0);
                    err_d       = is_illegal;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            idx_q       <= '0;
            cin_q       <= 1'b0;
            acc_q       <= '0;
            result_q    <= '0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            idx_q       <= idx_d;
            cin_q       <= cin_d;
            acc_q       <= acc_d;
            result_q    <= result_d;
            carry_q     <= carry_d;
            zero_q      <= zero_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Gated by rst so nothing looks acceptable while reset is held
    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign carry     = carry_q;
    assign zero      = zero_q;
    assign err       = err_q;

endmodule

// File: tb/tb_alu_serial_sequencer.sv
// Self-checking bench for alu_serial_sequencer: directed cases plus randomized
// requests compared against an arithmetic reference model.
module tb_alu_serial_sequencer;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic [2:0]   op = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic         carry, zero, err;

    int checks = 0;
    int errors = 0;

    alu_serial_sequencer #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .carry(carry), .zero(zero), .err(err)
    );

    always #5 clk = ~clk;

    // Reference model from the opcode definitions, using whole-number arithmetic
    function automatic void model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] r, output logic c, output logic e);
        int s;
        r = '0; c = 1'b0; e = 1'b0;
        case (o)
            3'd0: r = a & b;
            3'd1: r = a | b;
            3'd2: r = a ^ b;
            3'd3: r = ~a;
            3'd4: begin s = int'(a) + int'(b); r = W'(s); c = (s >= (1 << W)); end
            3'd5: begin s = int'(a) - int'(b); r = W'(s); c = (int'(a) >= int'(b)); end
            default: e = 1'b1;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one request and returns the number of edges from accept to out_valid
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] o,
                          output int lat);
        int n = 0;
        while (!in_ready && n < 20) begin tick(); n++; end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL run_op_ready: in_ready=%b expected 1", in_ready);
        end
        A = a; B = b; op = o; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        A = W'($urandom); B = W'($urandom); op = 3'($urandom);
        lat = 0;
        while (!out_valid && lat < 20) begin tick(); lat++; end
    endtask

    task automatic finish_op();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        checks++;
        if ({in_ready, out_valid, result, carry, zero, err} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: rdy=%b ov=%b res=%h c=%b z=%b e=%b expected all 0",
                     in_ready, out_valid, result, carry, zero, err);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_release_ready: in_ready=%b expected 1", in_ready);
        end
    endtask

    task automatic test_directed(input string name, input logic [2:0] o, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic [W-1:0] exp_r,
                                 input logic exp_c, input logic exp_z, input logic exp_e);
        int lat;
        run_op(a, b, o, lat);
        checks++;
        if (lat != W) begin
            errors++;
            $display("[TB] FAIL %s_latency: %0d edges expected %0d", name, lat, W);
        end
        checks++;
        if ({result, carry, zero, err} !== {exp_r, exp_c, exp_z, exp_e}) begin
            errors++;
            $display("[TB] FAIL %s_result: res=%b c=%b z=%b e=%b expected res=%b c=%b z=%b e=%b",
                     name, result, carry, zero, err, exp_r, exp_c, exp_z, exp_e);
        end
        finish_op();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== exp_r) begin
            errors++;
            $display("[TB] FAIL %s_handoff: ov=%b rdy=%b res=%b expected ov=0 rdy=1 res=%b",
                     name, out_valid, in_ready, result, exp_r);
        end
    endtask

    task automatic test_hold();
        int lat;
        logic [W-1:0] r0;
        logic c0, z0, e0;
        run_op(4'b0110, 4'b0011, 3'd4, lat);
        r0 = result; c0 = carry; z0 = zero; e0 = err;
        checks++;
        if (lat != W || r0 !== 4'b1001 || c0 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL hold_setup: lat=%0d res=%b c=%b expected lat=%0d res=1001 c=0",
                     lat, r0, c0, W);
        end
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            A = W'($urandom); B = W'($urandom); op = 3'($urandom_range(0, 5));
            tick();
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
                {result, carry, zero, err} !== {r0, c0, z0, e0}) begin
                errors++;
                $display("[TB] FAIL hold_cycle%0d: ov=%b rdy=%b res=%b c=%b z=%b e=%b expected ov=1 rdy=0 res=%b c=%b z=%b e=%b",
                         i, out_valid, in_ready, result, carry, zero, err, r0, c0, z0, e0);
            end
        end
        in_valid = 1'b0;
        finish_op();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== r0) begin
            errors++;
            $display("[TB] FAIL hold_release: ov=%b rdy=%b res=%b expected ov=0 rdy=1 res=%b",
                     out_valid, in_ready, result, r0);
        end
    endtask

    task automatic test_reset_mid();
        A = 4'b0111; B = 4'b0110; op = 3'd4; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        checks++;
        if ({in_ready, out_valid, result, carry, zero, err} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_mid_outputs: rdy=%b ov=%b res=%b c=%b z=%b e=%b expected all 0",
                     in_ready, out_valid, result, carry, zero, err);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_mid_ready: in_ready=%b expected 1", in_ready);
        end
        for (int i = 0; i < W + 2; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("[TB] FAIL reset_mid_idle%0d: ov=%b rdy=%b expected ov=0 rdy=1",
                         i, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [W-1:0] er;
        logic ec, ee;
        run_op(4'b1010, 4'b0110, 3'd2, lat);
        A = 4'b1001; B = 4'b1100; op = 3'd5; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_no_accept_on_handoff: rdy=%b ov=%b expected rdy=1 ov=0",
                     in_ready, out_valid);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_accept: in_ready=%b expected 0", in_ready);
        end
        lat = 0;
        while (!out_valid && lat < 20) begin tick(); lat++; end
        model(3'd5, 4'b1001, 4'b1100, er, ec, ee);
        checks++;
        if (lat != W || {result, carry, err} !== {er, ec, ee}) begin
            errors++;
            $display("[TB] FAIL b2b_second: lat=%0d res=%b c=%b e=%b expected lat=%0d res=%b c=%b e=%b",
                     lat, result, carry, err, W, er, ec, ee);
        end
        finish_op();
    endtask

    task automatic test_random();
        int lat;
        logic [W-1:0] a, b, er;
        logic [2:0] o;
        logic ec, ee;
        for (int i = 0; i < 40; i++) begin
            a = W'($urandom); b = W'($urandom); o = 3'($urandom_range(0, 7));
            run_op(a, b, o, lat);
            model(o, a, b, er, ec, ee);
            checks++;
            if (lat != W || {result, carry, zero, err} !== {er, ec, (er == '0), ee}) begin
                errors++;
                $display("[TB] FAIL random%0d op=%0d a=%b b=%b: lat=%0d res=%b c=%b z=%b e=%b expected lat=%0d res=%b c=%b z=%b e=%b",
                         i, o, a, b, lat, result, carry, zero, err, W, er, ec, (er == '0), ee);
            end
            repeat ($urandom_range(0, 3)) tick();
            finish_op();
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL random%0d_handoff: out_valid=%b expected 0", i, out_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed("and",     3'd0, 4'b1100, 4'b1010, 4'b1000, 1'b0, 1'b0, 1'b0);
        test_directed("add_ovf", 3'd4, 4'b1111, 4'b0001, 4'b0000, 1'b1, 1'b1, 1'b0);
        test_directed("sub_neg", 3'd5, 4'b0011, 4'b0101, 4'b1110, 1'b0, 1'b0, 1'b0);
        test_directed("sub_pos", 3'd5, 4'b0101, 4'b0011, 4'b0010, 1'b1, 1'b0, 1'b0);
        test_directed("illegal", 3'd7, 4'b1111, 4'b1111, 4'b0000, 1'b0, 1'b1, 1'b1);
        test_directed("not",     3'd3, 4'b0101, 4'b1111, 4'b1010, 1'b0, 1'b0, 1'b0);
        test_hold();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
